csqrt_rr_scheduler: RTL and testbench
=====================================

// Module: csqrt_rr_scheduler
// PURPOSE
//  Round-robin scheduler sharing one complex square-root engine (CV/CR CORDIC pair) among NUM_REQ requesters.
//  - Accepts one (x,y) job at a time and pulses the engine start.
//  - Waits for the engine valid and returns the result tagged with the requester id.
//  - Sits between the client blocks and the square-root engine top; it is the only driver of the engine inputs.
// PARAMETERS
//  NUM_REQ      4      number of requesters, 2..8
//  ID_W         2      resp_id width, must equal clog2(NUM_REQ)
//  ITER_N       8'd12  iteration count driven on eng_n
//  TIMEOUT_CYC  1024   WAIT watchdog limit in cycles; used only with CSQ_SCHED_TIMEOUT_EN
// PORTS
//  clk          in   1           single clock, rising edge
//  rst          in   1           asynchronous, active-low reset
//  req_valid    in   NUM_REQ     per-requester job request, held until accepted
//  req_ready    out  NUM_REQ     one-hot accept pulse, 1 cycle
//  req_x        in   16*NUM_REQ  signed real parts; requester i at [16i+15:16i]
//  req_y        in   16*NUM_REQ  signed imaginary parts, same packing
//  eng_start    out  1           1-cycle engine start pulse
//  eng_x        out  16          signed real operand to engine
//  eng_y        out  16          signed imaginary operand to engine
//  eng_n        out  8           iteration count to engine
//  eng_valid    in   1           engine result valid
//  eng_real     in   16          signed engine result, real part
//  eng_imag     in   16          signed engine result, imaginary part
//  resp_valid   out  1           result available
//  resp_ready   in   1           consumer accepts result
//  resp_id      out  ID_W        requester index owning the result
//  resp_real    out  16          registered result, real part
//  resp_imag    out  16          registered result, imaginary part
//  resp_err     out  1           timeout flag, qualified by resp_valid
//  busy         out  1           1 in every state except IDLE
// BEHAVIOUR
//  Reset (rst=0, async):
//  - State=IDLE; all outputs 0; eng_n=ITER_N.
//  - last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
//  - Reset mid-job abandons the job silently. No response is issued.
//  FSM states IDLE, LAUNCH, WAIT, RESP (registered; all outputs registered):
//  - IDLE: if any req_valid, scan from last_grant+1 with wrap-around. The first set bit wins.
//    Latch x/y into eng_x/eng_y, latch id, pulse req_ready[id] one cycle, go to LAUNCH.
//  - LAUNCH: eng_start=1 for exactly one cycle, go to WAIT. eng_x/eng_y/eng_n stay stable until the next acceptance.
//  - WAIT: on eng_valid, capture eng_real/eng_imag into resp_real/resp_imag, resp_err=0, go to RESP.
//  - RESP: resp_valid=1, data stable until resp_ready=1. On handshake: resp_valid=0, last_grant=id, go to IDLE.
//  Latency (acceptance in cycle T):
//  - eng_start is high in T+1.
//  - eng_valid in cycle E gives resp_valid=1 in E+1.
//  - With resp_ready tied high, the next acceptance is no earlier than E+2.
//  Boundary rules:
//  - eng_valid outside WAIT (including the LAUNCH cycle) is ignored.
//  - Non-granted requesters keep waiting; no req_ready is asserted while busy.
//  - req_valid dropping before acceptance is legal and is simply not scheduled.
//  - A lone active requester is served back-to-back.
//  - Fairness: under continuous requests each requester is served once per NUM_REQ jobs.
// CONFIGURATION
//  CSQ_SCHED_TIMEOUT_EN defined:
//  - A 16-bit counter clears on LAUNCH and increments in WAIT.
//  - Counter reaching TIMEOUT_CYC without eng_valid: go to RESP with resp_real=resp_imag=0 and resp_err=1.
//  - A late eng_valid from the timed-out job, arriving in IDLE, LAUNCH or RESP, is ignored.
//  CSQ_SCHED_TIMEOUT_EN undefined:
//  - No counter. WAIT lasts until eng_valid. resp_err is tied to 0.
// TESTING
//  Engine stub: eng_valid 20 cycles after eng_start; returns real=16'h0123, imag=16'h0456.
//  - Single job: req_valid=4'b0010, x=100, y=-200 -> req_ready=4'b0010 for 1 cycle; eng_start next cycle with eng_x=100, eng_y=-200, eng_n=12; resp_valid 21 cycles after eng_start, resp_id=1, resp_real=16'h0123.
//  - All 4 requesters valid continuously, resp_ready=1 -> grant order 0,1,2,3,0,1; no req_ready overlap.
//  - resp_ready held 0 for 10 cycles in RESP -> resp_* stable; no req_ready and no eng_start.
//  - rst=0 during WAIT -> all outputs 0 immediately. After release with req 2 and 3 valid -> 2 granted first.
//  - Spurious eng_valid in IDLE and during LAUNCH -> no resp_valid; captured data unchanged.
//  - Macro on, TIMEOUT_CYC=64, stub silent -> resp_valid with resp_err=1 and data 0, 65 cycles after eng_start. Macro off -> busy stays 1 indefinitely.

Source files
------------

// File: rtl/csqrt_rr_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : csqrt_rr_scheduler                                              |
// | Brief    : Round-robin arbiter sharing one complex square-root engine      |
// |            among NUM_REQ requesters; optional WAIT watchdog enabled by     |
// |            the CSQ_SCHED_TIMEOUT_EN macro.                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module csqrt_rr_scheduler #(
    parameter int         NUM_REQ     = 4,
    parameter int         ID_W        = 2,
    parameter logic [7:0] ITER_N      = 8'd12,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [16*NUM_REQ-1:0]  req_x,
    input  logic [16*NUM_REQ-1:0]  req_y,
    output logic                   eng_start,
    output logic [15:0]            eng_x,
    output logic [15:0]            eng_y,
    output logic [7:0]             eng_n,
    input  logic                   eng_valid,
    input  logic [15:0]            eng_real,
    input  logic [15:0]            eng_imag,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [15:0]            resp_real,
    output logic [15:0]            resp_imag,
    output logic                   resp_err,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      last_q, last_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 eng_start_q, eng_start_d;
    logic [15:0]          eng_x_q, eng_x_d;
    logic [15:0]          eng_y_q, eng_y_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [15:0]          resp_real_q, resp_real_d;
    logic [15:0]          resp_imag_q, resp_imag_d;
    logic                 resp_err_q, resp_err_d;
    logic                 busy_q, busy_d;

    logic                 gnt_found;
    logic [ID_W-1:0]      gnt_id;

`ifdef CSQ_SCHED_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);
    logic [15:0]          cnt_q, cnt_d;
`else
    localparam int unused_timeout = TIMEOUT_CYC;
`endif

    // Scan starts one past the previous winner so every requester gets a turn.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && req_valid[ID_W'((int'(last_q) + 1 + i) % NUM_REQ)]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'((int'(last_q) + 1 + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        id_d         = id_q;
        req_ready_d  = '0;
        eng_start_d  = 1'b0;
        eng_x_d      = eng_x_q;
        eng_y_d      = eng_y_q;
        resp_valid_d = resp_valid_q;
        resp_real_d  = resp_real_q;
        resp_imag_d  = resp_imag_q;
        resp_err_d   = resp_err_q;
`ifdef CSQ_SCHED_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    id_d                = gnt_id;
                    eng_x_d             = req_x[{gnt_id, 4'b0000} +: 16];
                    eng_y_d             = req_y[{gnt_id, 4'b0000} +: 16];
                    req_ready_d[gnt_id] = 1'b1;
                    state_d             = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                eng_start_d = 1'b1;
                state_d     = S_WAIT;
`ifdef CSQ_SCHED_TIMEOUT_EN
                cnt_d       = '0;
`endif
            end
            S_WAIT: begin
                if (eng_valid) begin
                    resp_real_d  = eng_real;
                    resp_imag_d  = eng_imag;
                    resp_err_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
`ifdef CSQ_SCHED_TIMEOUT_EN
                else if (cnt_q == TO_LIM) begin
                    resp_real_d  = '0;
                    resp_imag_d  = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    last_d       = id_q;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            last_q       <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            req_ready_q  <= '0;
            eng_start_q  <= 1'b0;
            eng_x_q      <= '0;
            eng_y_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_real_q  <= '0;
            resp_imag_q  <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            id_q         <= id_d;
            req_ready_q  <= req_ready_d;
            eng_start_q  <= eng_start_d;
            eng_x_q      <= eng_x_d;
            eng_y_q      <= eng_y_d;
            resp_valid_q <= resp_valid_d;
            resp_real_q  <= resp_real_d;
            resp_imag_q  <= resp_imag_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
        end
    end

`ifdef CSQ_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign req_ready  = req_ready_q;
    assign eng_start  = eng_start_q;
    assign eng_x      = eng_x_q;
    assign eng_y      = eng_y_q;
    assign eng_n      = ITER_N;
    assign resp_valid = resp_valid_q;
    assign resp_id    = id_q;
    assign resp_real  = resp_real_q;
    assign resp_imag  = resp_imag_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_csqrt_rr_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_csqrt_rr_scheduler                                           |
// | Brief    : Self-checking bench for csqrt_rr_scheduler with engine stub,    |
// |            job-timeline reference model and directed literal checks.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_csqrt_rr_scheduler;

    localparam int N   = 4;
    localparam int TO  = 64;
    localparam int LAT = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [16*N-1:0] req_x;
    logic [16*N-1:0] req_y;
    logic            eng_start;
    logic [15:0]     eng_x, eng_y;
    logic [7:0]      eng_n;
    logic            eng_valid;
    logic [15:0]     eng_real, eng_imag;
    logic            resp_valid;
    logic            resp_ready;
    logic [1:0]      resp_id;
    logic [15:0]     resp_real, resp_imag;
    logic            resp_err;
    logic            busy;

    always #5 clk = ~clk;

    csqrt_rr_scheduler #(
        .NUM_REQ    (N),
        .ID_W       (2),
        .ITER_N     (8'd12),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .eng_start (eng_start),
        .eng_x     (eng_x),
        .eng_y     (eng_y),
        .eng_n     (eng_n),
        .eng_valid (eng_valid),
        .eng_real  (eng_real),
        .eng_imag  (eng_imag),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id   (resp_id),
        .resp_real (resp_real),
        .resp_imag (resp_imag),
        .resp_err  (resp_err),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Engine stub and spurious-valid injector.
    logic stub_valid  = 1'b0;
    logic spur_valid  = 1'b0;
    bit   stub_silent = 1'b0;
    bit   stub_rand   = 1'b0;
    int   stub_due    = -1;
    assign eng_valid = stub_valid | spur_valid;

    // Reference model: one job timeline (acceptance cycle, response cycle).
    int           cyc      = 0;
    bit           m_active = 1'b0;
    int           t_acc    = 0;
    int           t_res    = -1;
    int           m_id     = 0;
    int           m_last   = N - 1;
    logic [15:0]  m_x = '0, m_y = '0, m_rr = '0, m_ri = '0;
    bit           m_err = 1'b0;
    logic [N-1:0] e_req_ready = '0;
    bit           e_eng_start = 1'b0, e_resp_valid = 1'b0, e_busy = 1'b0;

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int w;
        cyc++;
        stub_valid = (stub_due == cyc);
        eng_real   = (stub_valid && !stub_rand) ? 16'h0123 : 16'($urandom);
        eng_imag   = (stub_valid && !stub_rand) ? 16'h0456 : 16'($urandom);
        if (!rst) begin
            m_active = 1'b0; m_last = N - 1; m_err = 1'b0;
            m_x = '0; m_y = '0; m_rr = '0; m_ri = '0; m_id = 0;
            e_req_ready = '0; e_eng_start = 1'b0; e_resp_valid = 1'b0; e_busy = 1'b0;
            stub_due = -1; stub_valid = 1'b0;
        end
        chk("req_ready", req_ready, e_req_ready);
        chk("eng_start", eng_start, e_eng_start);
        chk("eng_x", eng_x, m_x);
        chk("eng_y", eng_y, m_y);
        chk("eng_n", eng_n, 8'd12);
        chk("resp_valid", resp_valid, e_resp_valid);
        chk("resp_real", resp_real, m_rr);
        chk("resp_imag", resp_imag, m_ri);
        chk("resp_err", resp_err, m_err);
        chk("busy", busy, e_busy);
        if (e_resp_valid) chk("resp_id", resp_id, m_id[1:0]);
        if (rst && eng_start && !stub_silent)
            stub_due = cyc + (stub_rand ? int'($urandom_range(1, 30)) : LAT);
        if (rst) begin
            e_req_ready = '0;
            if (!m_active) begin
                w = rr_pick(req_valid, m_last);
                if (w >= 0) begin
                    m_active = 1'b1; t_acc = cyc + 1; t_res = -1; m_id = w;
                    m_x = req_x[16*w +: 16]; m_y = req_y[16*w +: 16];
                    e_req_ready[w] = 1'b1;
                end
            end else if (t_res < 0) begin
                if (cyc >= t_acc + 1 && (stub_valid || spur_valid)) begin
                    t_res = cyc + 1; m_rr = eng_real; m_ri = eng_imag; m_err = 1'b0;
                end
`ifdef CSQ_SCHED_TIMEOUT_EN
                else if (cyc == t_acc + 1 + TO) begin
                    t_res = cyc + 1; m_rr = '0; m_ri = '0; m_err = 1'b1;
                end
`endif
            end else if (resp_ready) begin
                m_active = 1'b0; m_last = m_id;
            end
            e_eng_start  = m_active && (cyc == t_acc);
            e_resp_valid = m_active && (t_res >= 0);
            e_busy       = m_active;
        end
    end

    // Stimulus.
    bit drop_on_grant = 1'b1;
    bit rand_mode     = 1'b0;
    int rst_hold      = 0;

    task automatic step();
        @(posedge clk);
        #2;
        if (drop_on_grant) req_valid = req_valid & ~req_ready;
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 3) == 0)) begin
                    req_valid[i]      = 1'b1;
                    req_x[16*i +: 16] = 16'($urandom);
                    req_y[16*i +: 16] = 16'($urandom);
                end else if (req_valid[i] && ($urandom_range(0, 63) == 0)) begin
                    req_valid[i] = 1'b0;
                end
            end
            resp_ready = ($urandom_range(0, 2) != 0);
            spur_valid = ($urandom_range(0, 49) == 0);
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst = 1'b1;
            end else if ($urandom_range(0, 999) == 0) begin
                rst = 1'b0; rst_hold = 2;
            end
        end
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic wait_grant(output logic [N-1:0] g);
        g = '0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (req_ready != 0) begin
                g = req_ready;
                break;
            end
        end
        if (g == 0) chk("wait_grant_timeout", 0, 1);
    endtask

    task automatic wait_start();
        bit seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (eng_start) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("wait_start_timeout", 0, 1);
    endtask

    task automatic count_to_resp(input int limit, output int n);
        n = 0;
        for (int k = 1; k <= limit; k++) begin
            step();
            if (resp_valid) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && (busy || req_valid != 0); k++) step();
        chk("drain_idle", busy, 1'b0);
    endtask

    initial begin
        logic [N-1:0] g;
        int           n;
        int           order[6];
        rst = 1'b0; req_valid = '0; req_x = '0; req_y = '0; resp_ready = 1'b0;
        step();
        step();
        chk("reset_busy", busy, 1'b0);
        chk("reset_eng_n", eng_n, 8'd12);
        rst = 1'b1;
        step();

        // Single job from requester 1, response held for 10 cycles.
        req_valid = 4'b0010;
        req_x[31:16] = 16'd100;
        req_y[31:16] = 16'hFF38;
        wait_grant(g);
        chk("single_grant", g, 4'b0010);
        step();
        chk("single_start", eng_start, 1'b1);
        chk("single_x", eng_x, 16'd100);
        chk("single_y", eng_y, 16'hFF38);
        count_to_resp(100, n);
        chk("single_latency", n, 21);
        chk("single_id", resp_id, 2'd1);
        chk("single_real", resp_real, 16'h0123);
        chk("single_imag", resp_imag, 16'h0456);
        req_valid[0] = 1'b1;
        repeat (10) step();
        chk("hold_valid", resp_valid, 1'b1);
        chk("hold_real", resp_real, 16'h0123);
        resp_ready = 1'b1;
        drain();

        // Continuous requests from everyone: strict rotation after reset.
        reset_dut();
        drop_on_grant = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wait_grant(g);
            order[k] = -1;
            for (int i = 0; i < N; i++) if (g[i]) order[k] = i;
        end
        for (int k = 0; k < 6; k++) chk("rr_order", order[k], k % N);

        // Reset during WAIT, then requesters 2 and 3 compete.
        wait_start();
        repeat (5) step();
        rst = 1'b0;
        req_valid = 4'b1100;
        #1;
        chk("async_rst_outs", {req_ready, eng_start, resp_valid, busy, resp_err}, 0);
        chk("async_rst_data", {eng_x, resp_real}, 0);
        step();
        step();
        rst = 1'b1;
        wait_grant(g);
        chk("post_rst_grant", g, 4'b0100);
        req_valid[2] = 1'b0;
        drop_on_grant = 1'b1;
        drain();

        // Spurious engine valid in IDLE and during LAUNCH.
        spur_valid = 1'b1;
        step();
        spur_valid = 1'b0;
        step();
        chk("spur_idle", resp_valid, 1'b0);
        req_valid[3] = 1'b1;
        req_x[63:48] = 16'h7FFF;
        req_y[63:48] = 16'h8000;
        wait_grant(g);
        chk("spur_grant", g, 4'b1000);
        spur_valid = 1'b1;
        step();
        spur_valid = 1'b0;
        chk("spur_start", eng_start, 1'b1);
        chk("spur_launch", resp_valid, 1'b0);
        count_to_resp(100, n);
        chk("spur_latency", n, 21);
        chk("spur_real", resp_real, 16'h0123);
        chk("spur_id", resp_id, 2'd3);
        drain();

        // Silent engine.
        stub_silent = 1'b1;
        req_valid[0] = 1'b1;
        wait_start();
`ifdef CSQ_SCHED_TIMEOUT_EN
        count_to_resp(200, n);
        chk("timeout_latency", n, 65);
        chk("timeout_err", resp_err, 1'b1);
        chk("timeout_data", {resp_real, resp_imag}, 0);
        drain();
`else
        repeat (200) step();
        chk("stuck_busy", busy, 1'b1);
        chk("stuck_resp", resp_valid, 1'b0);
        reset_dut();
`endif
        stub_silent = 1'b0;

        // Randomized traffic.
        stub_rand = 1'b1;
        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode  = 1'b0;
        spur_valid = 1'b0;
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
